// File: rtl/spi_slave_responder.sv
// spi_slave_responder
// Mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave endpoint. All pin inputs are
// oversampled in the clk domain. The parallel side has a one-entry TX
// holding buffer (valid/ready) and an RX word output with a one-cycle
// valid pulse.
//
// Pipeline from pin to action (SYNC_STAGES = S):
//   S synchronizer flops -> edge detect against a history flop -> registered
//   edge pulse -> FSM/datapath action -> registered outputs.
// rx_valid and the first MISO bit therefore appear S+2 cycles after the clk
// edge that first samples the pin change.
//
// Frame reload happens on the first sck fall after the last rise of a frame.
// A master that drops sck before raising ss_n at the end of its last frame
// will pull the next buffered word into the shifter, and that word is then
// lost when ss_n rises.
module spi_slave_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Word placed into the shifter on a frame load: buffer contents when the
  // buffer is full, all zeros on an underrun.
  function automatic logic [DATA_WIDTH-1:0] frame_word(
    input logic                  full,
    input logic [DATA_WIDTH-1:0] word
  );
    if (full) begin
      frame_word = word;
    end else begin
      frame_word = {DATA_WIDTH{1'b0}};
    end
  endfunction

  // Synchronizers and edge history
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sck_hist_r;
  logic                   ss_hist_r;

  // Combinational edge detects
  logic sck_rise_s;
  logic sck_fall_s;
  logic ss_fall_s;
  logic ss_rise_s;

  // Registered edge pulses
  logic sck_rise_r;
  logic sck_fall_r;
  logic ss_fall_r;
  logic ss_rise_r;

  // Post-reset arming: the synchronizer pipeline must be flushed with real
  // pin values and ss_n seen high before a falling edge may start a frame.
  logic [SYNC_STAGES:0] flush_r;
  logic                 armed_r;

  // FSM and datapath
  state_t                  state_r;
  state_t                  state_next_s;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0]   tx_shift_r;
  logic [DATA_WIDTH-1:0]   rx_shift_r;
  logic                    reload_r;
  logic                    done_r;

  logic load_s;
  logic shift_s;
  logic capture_s;
  logic frame_done_s;
  logic abort_s;

  // TX holding buffer
  logic                  buf_full_r;
  logic [DATA_WIDTH-1:0] buf_data_r;
  logic                  accept_s;
  logic                  consume_s;

  // Registered outputs
  logic                  miso_r;
  logic                  miso_oe_r;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  rx_valid_r;
  logic                  tx_underrun_r;
  logic                  busy_r;

  // Sample the pins through SYNC_STAGES flops and keep one history flop per
  // edge-detected input; reset loads the idle pin levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_hist_r  <= 1'b0;
      ss_hist_r   <= 1'b1;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sck_hist_r  <= sck_sync_r[SYNC_STAGES-1];
      ss_hist_r   <= ss_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_rise_s = sck_sync_r[SYNC_STAGES-1] & ~sck_hist_r;
  assign sck_fall_s = ~sck_sync_r[SYNC_STAGES-1] & sck_hist_r;
  assign ss_fall_s  = ~ss_sync_r[SYNC_STAGES-1] & ss_hist_r;
  assign ss_rise_s  = ss_sync_r[SYNC_STAGES-1] & ~ss_hist_r;

  // Track pipeline flush after reset and arm frame starts once ss_n is
  // genuinely observed high at the pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_r <= {(SYNC_STAGES + 1){1'b0}};
      armed_r <= 1'b0;
    end else begin
      flush_r <= {flush_r[SYNC_STAGES-1:0], 1'b1};
      armed_r <= armed_r | (flush_r[SYNC_STAGES] & ss_sync_r[SYNC_STAGES-1] & ss_hist_r);
    end
  end

  // Register the edge pulses; a slave-select fall only counts once armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_rise_r <= 1'b0;
      sck_fall_r <= 1'b0;
      ss_fall_r  <= 1'b0;
      ss_rise_r  <= 1'b0;
    end else begin
      sck_rise_r <= sck_rise_s;
      sck_fall_r <= sck_fall_s;
      ss_fall_r  <= ss_fall_s & armed_r;
      ss_rise_r  <= ss_rise_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle action decode; ss_rise beats a same-cycle sck
  // edge so a bit clocked while deselecting is ignored.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    capture_s    = 1'b0;
    frame_done_s = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_fall_r) begin
          state_next_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (ss_rise_r) begin
          state_next_s = IDLE;
          abort_s      = 1'b1;
        end else begin
          state_next_s = SHIFT;
          if (sck_rise_r) begin
            capture_s = 1'b1;
            if (bit_cnt_r == LAST_BIT) begin
              frame_done_s = 1'b1;
            end else begin
              frame_done_s = 1'b0;
            end
          end else begin
            capture_s = 1'b0;
          end
          if (sck_fall_r) begin
            if (reload_r) begin
              load_s = 1'b1;
            end else begin
              shift_s = 1'b1;
            end
          end else begin
            shift_s = 1'b0;
          end
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Shift registers, bit counter, reload flag and frame-complete pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r  <= {CNT_W{1'b0}};
      tx_shift_r <= {DATA_WIDTH{1'b0}};
      rx_shift_r <= {DATA_WIDTH{1'b0}};
      reload_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (abort_s || load_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
      end else if (capture_s) begin
        if (frame_done_s) begin
          bit_cnt_r <= {CNT_W{1'b0}};
        end else begin
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
      end

      if (load_s) begin
        tx_shift_r <= frame_word(buf_full_r, buf_data_r);
      end else if (shift_s) begin
        tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
      end

      if (capture_s) begin
        rx_shift_r <= {rx_shift_r[DATA_WIDTH-2:0], mosi_sync_r[SYNC_STAGES-1]};
      end

      if (abort_s) begin
        reload_r <= 1'b0;
      end else if (frame_done_s) begin
        reload_r <= 1'b1;
      end else if (load_s) begin
        reload_r <= 1'b0;
      end

      done_r <= frame_done_s;
    end
  end

  assign accept_s  = tx_valid & ~buf_full_r;
  assign consume_s = load_s & buf_full_r;

  // One-entry TX holding buffer; a frame load hands the stored word to the
  // shifter before any newly accepted word overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_r <= 1'b0;
      buf_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        buf_full_r <= 1'b1;
        buf_data_r <= tx_data;
      end else if (consume_s) begin
        buf_full_r <= 1'b0;
      end
    end
  end

  // Output registers: MISO/OE follow the shifter and FSM, RX word and
  // status pulses are presented one cycle after the event that makes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
      rx_data_r     <= {DATA_WIDTH{1'b0}};
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      miso_oe_r <= (state_r == SHIFT);
      if (state_r == SHIFT) begin
        miso_r <= tx_shift_r[DATA_WIDTH-1];
      end else begin
        miso_r <= 1'b0;
      end
      rx_valid_r <= done_r;
      if (done_r) begin
        rx_data_r <= rx_shift_r;
      end
      tx_underrun_r <= load_s & ~buf_full_r;
      busy_r        <= (state_next_s != IDLE);
    end
  end

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign tx_ready    = ~buf_full_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Testbench for spi_slave_responder: a bench SPI master drives directed
// frames, expected RX words and MISO words are queued as stimulus is issued,
// and independent monitors pop and compare when the DUT presents data.
module tb_spi_slave_responder;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sck = 1'b0;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic          miso_oe;
  logic [DW-1:0] tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_underrun;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int underrun_cnt = 0;
  bit mon_en = 1'b1;
  int miso_bits = 0;
  logic [7:0] miso_word = 8'h00;
  logic [7:0] rx_exp_q[$];
  logic [7:0] miso_exp_q[$];
  logic [7:0] rx_exp_w;
  logic [7:0] miso_exp_w;

  spi_slave_responder #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a word on the TX handshake; keep leaves tx_valid asserted.
  task automatic tx_send(input logic [7:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL tx_send_timeout: word 0x%0h never accepted", d);
    end
    if (!keep) tx_valid = 1'b0;
  endtask

  // Bench SPI master, mode 0, clk/8: mosi changes while sck low, 4 clk low
  // and 4 clk high per bit. With stop, ss_n rises before the final sck fall.
  task automatic spi_frame(input logic [7:0] w, input int nbits, input bit start, input bit stop);
    if (start) begin
      ss_n = 1'b0;
      wait_clk(8);
      check("busy_in_frame", 32'(busy), 32'd1);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      wait_clk(4);
      sck = 1'b1;
      last_rise_cyc = cyc;
      wait_clk(4);
      if (stop && (i == nbits - 1)) begin
        ss_n = 1'b1;
        wait_clk(4);
      end
      sck = 1'b0;
    end
    if (stop) wait_clk(8);
  endtask

  // RX monitor: every rx_valid must match the next queued word and arrive
  // SS+2 cycles after the edge that first samples the last sck rise.
  always @(negedge clk) begin
    if (rst === 1'b0 && rx_valid === 1'b1) begin
      if (rx_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got rx_data 0x%0h, expected no rx_valid", rx_data);
      end else begin
        rx_exp_w = rx_exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(rx_exp_w));
        check("rx_latency", 32'(cyc - last_rise_cyc - 1), 32'(SS + 2));
      end
    end
    if (tx_underrun === 1'b1) underrun_cnt++;
  end

  // MISO monitor: samples late in each sck high phase, like the master
  // would, and compares every completed 8-bit word with the queue.
  initial begin
    forever begin
      @(posedge sck);
      if (ss_n === 1'b0 && mon_en) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("miso_oe", 32'(miso_oe), 32'd1);
        miso_word = {miso_word[6:0], miso};
        miso_bits++;
        if (miso_bits == 8) begin
          miso_bits = 0;
          if (miso_exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL miso_unexpected: got word 0x%0h, expected none", miso_word);
          end else begin
            miso_exp_w = miso_exp_q.pop_front();
            check("miso_word", 32'(miso_word), 32'(miso_exp_w));
          end
        end
      end
    end
  end

  always @(posedge ss_n) miso_bits = 0;

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clk(6);

    // Single frame: send 0xA5, receive 0x3C
    tx_send(8'hA5, 1'b0);
    check("t1_tx_ready_low", 32'(tx_ready), 32'd0);
    miso_exp_q.push_back(8'hA5);
    rx_exp_q.push_back(8'h3C);
    spi_frame(8'h3C, 8, 1'b1, 1'b1);
    check("t1_tx_ready_high", 32'(tx_ready), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_underruns", 32'(underrun_cnt), 32'd0);

    // Back-to-back frames with ss_n held low, buffer refilled mid-frame
    tx_send(8'h11, 1'b0);
    miso_exp_q.push_back(8'h11);
    miso_exp_q.push_back(8'h22);
    rx_exp_q.push_back(8'hF0);
    rx_exp_q.push_back(8'h0F);
    fork
      begin
        spi_frame(8'hF0, 8, 1'b1, 1'b0);
        spi_frame(8'h0F, 8, 1'b0, 1'b1);
      end
      begin
        wait_clk(30);
        tx_send(8'h22, 1'b0);
      end
    join
    check("t2_underruns", 32'(underrun_cnt), 32'd0);
    check("t2_tx_ready", 32'(tx_ready), 32'd1);

    // Frame with empty TX buffer
    miso_exp_q.push_back(8'h00);
    rx_exp_q.push_back(8'h81);
    spi_frame(8'h81, 8, 1'b1, 1'b1);
    check("t3_underruns", 32'(underrun_cnt), 32'd1);
    check("t3_rx_data", 32'(rx_data), 32'h81);

    // Aborted partial frame, then a full frame
    tx_send(8'h77, 1'b0);
    spi_frame(8'hC3, 5, 1'b1, 1'b1);
    check("t4_busy_after_abort", 32'(busy), 32'd0);
    check("t4_rx_data_kept", 32'(rx_data), 32'h81);
    check("t4_tx_ready", 32'(tx_ready), 32'd1);
    tx_send(8'h96, 1'b0);
    miso_exp_q.push_back(8'h96);
    rx_exp_q.push_back(8'h5A);
    spi_frame(8'h5A, 8, 1'b1, 1'b0);
    ss_n = 1'b1;
    wait_clk(12);
    check("t4_rx_data_new", 32'(rx_data), 32'h5A);
    check("t4_underruns", 32'(underrun_cnt), 32'd1);

    // Reset in the middle of a frame
    mon_en = 1'b0;
    tx_send(8'hC3, 1'b0);
    spi_frame(8'hE7, 4, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_miso", 32'(miso), 32'd0);
    check("t5_miso_oe", 32'(miso_oe), 32'd0);
    check("t5_tx_ready", 32'(tx_ready), 32'd1);
    check("t5_rx_data", 32'(rx_data), 32'h00);
    check("t5_rx_valid", 32'(rx_valid), 32'd0);
    check("t5_tx_underrun", 32'(tx_underrun), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    spi_frame(8'h7E, 4, 1'b0, 1'b1);
    check("t5_busy_ignored", 32'(busy), 32'd0);
    check("t5_rx_data_still", 32'(rx_data), 32'h00);
    mon_en = 1'b1;
    tx_send(8'h3D, 1'b0);
    miso_exp_q.push_back(8'h3D);
    rx_exp_q.push_back(8'hE7);
    spi_frame(8'hE7, 8, 1'b1, 1'b1);
    check("t5_rx_data_new", 32'(rx_data), 32'hE7);

    // tx_valid held high: one word per frame load, order kept
    miso_exp_q.push_back(8'h01);
    miso_exp_q.push_back(8'h02);
    miso_exp_q.push_back(8'h03);
    rx_exp_q.push_back(8'h10);
    rx_exp_q.push_back(8'h20);
    rx_exp_q.push_back(8'h30);
    fork
      begin
        tx_send(8'h01, 1'b1);
        tx_send(8'h02, 1'b1);
        tx_send(8'h03, 1'b0);
      end
      begin
        spi_frame(8'h10, 8, 1'b1, 1'b1);
        spi_frame(8'h20, 8, 1'b1, 1'b1);
        spi_frame(8'h30, 8, 1'b1, 1'b1);
      end
    join
    check("t6_tx_ready", 32'(tx_ready), 32'd1);

    wait_clk(20);
    check("end_underruns", 32'(underrun_cnt), 32'd1);
    check("end_rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);
    check("end_miso_queue_empty", 32'(miso_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI responder (slave) endpoint for the mcont SPI master pins: sck, mosi, miso, one slave-select.
- Used as an on-board/bench peer of the protocol controller, and as a template for a peripheral-side SPI port.
- All SPI inputs are oversampled in the clk domain. Mode 0 (CPOL=0, CPHA=0), MSB first.
- Parallel side: a one-entry TX holding buffer with valid/ready handshake, and an RX word output with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sck, ss_n and mosi (minimum 2).

Ports:
- clk  in  1  system clock; sck must be at most clk/8.
- rst  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock from the master.
- ss_n  in  1  slave select from the master, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  miso drive enable (tristate control at the pad).
- tx_data  in  DATA_WIDTH  word to send in the next frame.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX holding buffer is empty.
- rx_data  out  DATA_WIDTH  last complete received frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse: a frame started with the TX buffer empty.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0. Synchronizers load idle levels: sck=0, ss_n=1, mosi=0. FSM=IDLE, bit_cnt=0, TX buffer empty.
- Synchronization: sck, ss_n and mosi each pass through SYNC_STAGES flops.
  - Edge detects (sck_rise, sck_fall, ss_fall, ss_rise) compare the last synced flop with one extra history flop.
- TX buffer:
  - A transfer is accepted when tx_valid & tx_ready; tx_ready drops the following cycle.
  - The buffer empties when a frame load consumes it; tx_ready rises the following cycle.
  - Accept and consume in the same cycle: the old entry is consumed and the new one is stored, so tx_ready stays 0.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on ss_fall. The same cycle performs a frame load:
    - tx_shift <= buffer if full;
    - otherwise tx_shift <= 0 and tx_underrun pulses.
    - bit_cnt <= 0.
  - In SHIFT, on sck_rise: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit_cnt <= bit_cnt+1.
    - When bit_cnt == DATA_WIDTH-1 on a rise, the frame completes:
      - rx_data <= assembled word and rx_valid=1 the next cycle, for exactly one cycle;
      - bit_cnt wraps to 0;
      - a reload flag is set.
  - In SHIFT, on sck_fall:
    - if the reload flag is set: frame load (same rules as above), then clear the flag;
    - otherwise tx_shift <= tx_shift << 1.
    - This supports back-to-back frames while ss_n stays low.
  - SHIFT -> IDLE on ss_rise from any bit position.
    - A partial frame is discarded: no rx_valid, rx_data unchanged, bit_cnt <= 0.
    - The TX buffer is not consumed unless a load already occurred.
  - ss_rise and sck_rise in the same cycle: ss_rise wins and the bit is ignored.
- miso = tx_shift[DATA_WIDTH-1] when miso_oe is 1, else 0.
  - miso_oe = 1 exactly while FSM == SHIFT.
- Latency:
  - rx_valid is high exactly SYNC_STAGES+2 clk cycles after the clk edge that first samples the final sck rise at the pin.
  - The first MISO bit is valid SYNC_STAGES+2 cycles after ss_n falls at the pin.
- busy = (FSM != IDLE).
- Reset mid-frame: all state returns to reset values immediately, with no rx_valid pulse. After release, a frame in progress on the pins is ignored until ss_n is seen high and then falls again.

Test Plan:
- Reset, then tx_valid with tx_data=0xA5; master sends 0x3C in one frame at clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_valid pulses once with rx_data=0x3C; tx_ready returns to 1 after the load.
- Two back-to-back frames with ss_n held low: TX buffer 0x11, refilled with 0x22 during frame 1; mosi 0xF0 then 0x0F -> miso sends 0x11 then 0x22; two rx_valid pulses with 0xF0 and 0x0F; no tx_underrun.
- Frame started with the TX buffer empty -> tx_underrun pulses once; miso is all zeros; rx_data is still captured correctly (mosi 0x81 -> rx_data=0x81).
- ss_n rises after 5 sck edges -> no rx_valid; rx_data keeps its previous value; busy=0; the next full frame of 0x5A is received correctly.
- Assert rst after 4 bits of a frame -> all outputs at reset values the same cycle; tx_ready=1; no rx_valid until a new ss_n falling edge plus 8 bits.
- tx_valid held high while the buffer is full -> exactly one word is accepted per frame load; the word order 0x01, 0x02, 0x03 is preserved across three frames.
